// File: rtl/rca_pipe_pkg.sv
// Shared defaults for the pipelined ripple-carry adder/subtractor.
// The top and the bench both take their default geometry from here.
package rca_pipe_pkg;

   // Default operand width and pipeline depth.
   localparam int DEF_WIDTH  = 32;
   localparam int DEF_STAGES = 4;

   // Bits of the addition resolved by each pipeline stage.
   localparam int DEF_SEG    = DEF_WIDTH / DEF_STAGES;

endpackage

// File: rtl/rca_pipe_seg.sv
// Ripple-carry segment adder and the full-adder cell it is built from.
// The segment is purely combinational; the pipeline registers live in the top.

// Single-bit full adder cell.
module rca_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// SEG-bit ripple-carry adder. Besides the carry out of the top bit it
// exposes the carry into the top bit so the caller can form signed overflow.
module rca_seg
   import rca_pipe_pkg::*;
#(
   parameter int SEG = DEF_SEG
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co,
   output logic           cm
);

   // Each bit keeps its own carry nets so the ripple chain is a plain
   // acyclic chain of separate signals rather than one self-feeding vector.
   for (genvar i = 0; i < SEG; i++) begin : g_bit
      logic c_i;
      logic c_o;

      if (i == 0) begin : g_lsb
         assign c_i = ci;
      end else begin : g_mid
         assign c_i = g_bit[i-1].c_o;
      end

      rca_fa u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c_i),
         .s  (s[i]),
         .co (c_o)
      );
   end

   assign co = g_bit[SEG-1].c_o;
   assign cm = g_bit[SEG-1].c_i;

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor with valid/ready on both sides.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is a pure function of out_valid/out_ready, so the whole
// pipeline advances in lock-step (adv) or holds in lock-step; empty slots are
// never squeezed out. Once out_valid rises, s/co/ovf stay stable until the
// edge that retires them.
//
// Datapath: stage j (0-based) adds segment j. The A path is a rotating word:
// each stage drops its consumed A segment off the bottom and inserts the fresh
// sum segment at the top, so after the last stage the word is the complete
// sum in place. The B path only carries the not-yet-consumed upper segments.
module rca_pipe
   import rca_pipe_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             ovf
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   logic             adv;
   logic             accept;
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   logic [WIDTH-1:0] s_next;

   // The pipeline moves whenever the output slot is free or being drained.
   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;
   assign accept   = in_valid & adv;

   // Subtraction is a + ~b + 1; the carry-in port is ignored in that case.
   assign b_eff = sub ? ~b : b;
   assign c0    = sub | ci;

   for (genvar j = 0; j < STAGES; j++) begin : g_stage
      // Width of the B operand still to be consumed at this stage.
      localparam int BW = WIDTH - j * SEG;

      logic [WIDTH-1:0] ap_in;
      logic [BW-1:0]    b_in;
      logic             c_in;
      logic             v_in;
      logic [SEG-1:0]   seg_s;
      logic             seg_co;
      logic             seg_cm;

      if (j == 0) begin : g_head
         assign ap_in = a;
         assign b_in  = b_eff;
         assign c_in  = c0;
         assign v_in  = accept;
      end else begin : g_reg
         logic [WIDTH-1:0] ap_q;
         logic [BW-1:0]    b_q;
         logic             c_q;
         logic             v_q;

         // Stage register: capture the previous stage's partial result and the
         // remaining operands; invalid slots advance too and are simply ignored.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               ap_q <= '0;
               b_q  <= '0;
               c_q  <= 1'b0;
               v_q  <= 1'b0;
            end else if (adv) begin
               ap_q <= {g_stage[j-1].seg_s, g_stage[j-1].ap_in[WIDTH-1:SEG]};
               b_q  <= g_stage[j-1].b_in[BW+SEG-1:SEG];
               c_q  <= g_stage[j-1].seg_co;
               v_q  <= g_stage[j-1].v_in;
            end
         end

         assign ap_in = ap_q;
         assign b_in  = b_q;
         assign c_in  = c_q;
         assign v_in  = v_q;
      end

      rca_seg #(
         .SEG (SEG)
      ) u_seg (
         .a  (ap_in[SEG-1:0]),
         .b  (b_in[SEG-1:0]),
         .ci (c_in),
         .s  (seg_s),
         .co (seg_co),
         .cm (seg_cm)
      );
   end

   // Assemble the full sum leaving the last stage.
   if (STAGES == 1) begin : g_one
      assign s_next = g_stage[0].seg_s;
   end else begin : g_many
      assign s_next = {g_stage[LAST].seg_s, g_stage[LAST].ap_in[WIDTH-1:SEG]};
   end

   // Output register: valid follows the pipeline, result fields only load
   // when a valid result arrives so they never show data from empty slots.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         s         <= '0;
         co        <= 1'b0;
         ovf       <= 1'b0;
      end else if (adv) begin
         out_valid <= g_stage[LAST].v_in;
         if (g_stage[LAST].v_in) begin
            s   <= s_next;
            co  <= g_stage[LAST].seg_co;
            ovf <= g_stage[LAST].seg_co ^ g_stage[LAST].seg_cm;
         end
      end
   end

endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench for rca_pipe: directed vectors on the default
// 32-bit/4-stage build, plus 1-stage and 8-stage builds against a model.
module tb_rca_pipe;
   import rca_pipe_pkg::*;

   localparam int W  = DEF_WIDTH;
   localparam int ST = DEF_STAGES;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   // ---------------- main DUT ----------------
   logic         in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
   logic [W-1:0] a, b, s;

   rca_pipe #(.WIDTH(W), .STAGES(ST)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .co(co), .ovf(ovf)
   );

   // ---------------- sweep DUTs (1 and 8 stages) ----------------
   logic         sw_valid, sw_ci, sw_sub, sw_ready;
   logic [W-1:0] sw_a, sw_b;
   logic         in_ready1, out_valid1, co1, ovf1;
   logic         in_ready8, out_valid8, co8, ovf8;
   logic [W-1:0] s1, s8;

   rca_pipe #(.WIDTH(W), .STAGES(1)) dut1 (
      .clock(clock), .reset_n(reset_n), .in_valid(sw_valid), .in_ready(in_ready1),
      .a(sw_a), .b(sw_b), .ci(sw_ci), .sub(sw_sub), .out_valid(out_valid1),
      .out_ready(sw_ready), .s(s1), .co(co1), .ovf(ovf1)
   );

   rca_pipe #(.WIDTH(W), .STAGES(8)) dut8 (
      .clock(clock), .reset_n(reset_n), .in_valid(sw_valid), .in_ready(in_ready8),
      .a(sw_a), .b(sw_b), .ci(sw_ci), .sub(sw_sub), .out_valid(out_valid8),
      .out_ready(sw_ready), .s(s8), .co(co8), .ovf(ovf8)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain full-width arithmetic, packed as {co, ovf, s}.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic m);
      logic [W-1:0] ye;
      logic [W:0]   t;
      logic         v;
      ye = m ? ~y : y;
      t  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (m | c)};
      v  = (x[W-1] == ye[W-1]) && (t[W-1] != x[W-1]);
      return {t[W], v, t[W-1:0]};
   endfunction

   // ---------------- scoreboard for the main DUT ----------------
   logic [W+1:0] exp_q[$];

   always @(negedge clock) begin
      logic [W+1:0] exp_w;
      if (reset_n && out_valid && out_ready) begin
         check_eq("result_expected", (exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            check_eq("result", {co, ovf, s}, exp_w);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Present one operation and hold it until accepted; returns 1ns after the
   // accepting edge with in_valid still high.
   task automatic drive_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic xci, input logic xsub, input logic [W+1:0] e);
      bit ok;
      ok = 1'b0;
      a = xa; b = xb; ci = xci; sub = xsub; in_valid = 1'b1;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clock);
         if (in_ready) ok = 1'b1;
         else begin
            @(posedge clock); #1;
         end
      end
      check_eq("accept_ready", ok, 1);
      if (ok) begin
         exp_q.push_back(e);
         @(posedge clock); #1;
      end
   endtask

   // Count negedges until out_valid, bounded.
   task automatic wait_out(output int cnt);
      cnt = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (out_valid) begin
            cnt = k;
            break;
         end
      end
   endtask

   // One isolated operation with latency check.
   task automatic single_op(input string tag, input logic [W-1:0] xa, input logic [W-1:0] xb,
                            input logic xci, input logic xsub, input logic [W+1:0] e);
      int cnt;
      drive_op(xa, xb, xci, xsub, e);
      in_valid = 1'b0;
      wait_out(cnt);
      check_eq({tag, "_latency"}, cnt, ST);
      @(posedge clock); #1;
   endtask

   // ---------------- directed vectors ----------------
   logic [W-1:0] va[4];
   logic [W-1:0] vb[4];
   logic         vc[4];
   logic         vs[4];
   logic [W+1:0] ve[4];

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int           cnt, lat1, lat8;
      logic [W+1:0] e;

      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; ci = 1'b0; sub = 1'b0;
      sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0; sw_ready = 1'b1;

      // reset state
      #23;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_s", s, 0);
      check_eq("rst_co_ovf", {co, ovf}, 0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      #1;
      check_eq("rst_in_ready", in_ready, 1);

      // single adds
      single_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b1, 1'b0, 32'h0000_0000});
      single_op("add_fill", 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0, {1'b0, 1'b0, 32'hFFFF_FFFF});
      single_op("add_mix",  32'h135F_A562, 32'h3561_4642, 1'b0, 1'b0, {1'b0, 1'b0, 32'h48C0_EBA4});

      // back-to-back stream of the same three
      drive_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b1, 1'b0, 32'h0000_0000});
      drive_op(32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0, {1'b0, 1'b0, 32'hFFFF_FFFF});
      drive_op(32'h135F_A562, 32'h3561_4642, 1'b0, 1'b0, {1'b0, 1'b0, 32'h48C0_EBA4});
      in_valid = 1'b0;
      wait_out(cnt);
      check_eq("stream_first", (cnt > 0), 1);
      @(negedge clock);
      check_eq("stream_gap1", out_valid, 1);
      @(negedge clock);
      check_eq("stream_gap2", out_valid, 1);
      @(negedge clock);
      check_eq("stream_end", out_valid, 0);
      @(posedge clock); #1;

      // subtract and overflow
      single_op("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
      single_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h8000_0000});
      single_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});

      // backpressure: fill the pipe with out_ready low
      va = '{32'h0000_0001, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0010};
      vb = '{32'h0000_0002, 32'h1111_1111, 32'hFFFF_FFFF, 32'h0000_0010};
      vc = '{1'b0, 1'b0, 1'b1, 1'b0};
      vs = '{1'b0, 1'b0, 1'b0, 1'b1};
      ve = '{{1'b0, 1'b0, 32'h0000_0003}, {1'b0, 1'b0, 32'h2345_6789},
             {1'b1, 1'b0, 32'hFFFF_FFFF}, {1'b1, 1'b0, 32'h0000_0000}};
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) drive_op(va[i], vb[i], vc[i], vs[i], ve[i]);
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check_eq($sformatf("stall_in_ready_%0d", i), in_ready, 0);
         check_eq($sformatf("stall_s_%0d", i), {out_valid, s}, {1'b1, 32'h0000_0003});
      end
      check_eq("stall_queue", exp_q.size(), 4);
      @(posedge clock); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check_eq($sformatf("drain_valid_%0d", i), out_valid, 1);
      end
      @(negedge clock);
      check_eq("drain_no_dup", out_valid, 0);
      check_eq("drain_queue", exp_q.size(), 0);
      @(posedge clock); #1;

      // reset while a result is held at the output
      out_ready = 1'b0;
      drive_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, {1'b1, 1'b1, 32'h7FFF_FFFF});
      in_valid = 1'b0;
      wait_out(cnt);
      check_eq("held_result", {co, ovf, s}, {1'b1, 1'b1, 32'h7FFF_FFFF});
      #2;
      reset_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_s", s, 0);
      check_eq("midrst_co_ovf", {co, ovf}, 0);
      exp_q.delete();
      @(posedge clock); #1;
      out_ready = 1'b1;
      reset_n = 1'b1;
      #1;
      check_eq("postrst_in_ready", in_ready, 1);
      check_eq("postrst_out_valid", out_valid, 0);
      single_op("postrst_op", 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0000_0009});

      // parameter sweep: 1-stage and 8-stage builds against the model
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            sw_a = 32'hFFFF_FFFF; sw_b = 32'h0000_0000; sw_ci = 1'b1; sw_sub = 1'b0;
         end else begin
            sw_a = $urandom; sw_b = $urandom;
            sw_ci = 1'($urandom_range(0, 1)); sw_sub = 1'($urandom_range(0, 1));
         end
         e = model(sw_a, sw_b, sw_ci, sw_sub);
         sw_valid = 1'b1;
         check_eq($sformatf("sw_ready_%0d", i), {in_ready1, in_ready8}, 2'b11);
         @(posedge clock); #1;
         sw_valid = 1'b0;
         lat1 = 0; lat8 = 0;
         for (int k = 1; k <= 30 && (lat1 == 0 || lat8 == 0); k++) begin
            @(negedge clock);
            if (lat1 == 0 && out_valid1) begin
               lat1 = k;
               check_eq($sformatf("sw1_result_%0d", i), {co1, ovf1, s1}, e);
            end
            if (lat8 == 0 && out_valid8) begin
               lat8 = k;
               check_eq($sformatf("sw8_result_%0d", i), {co8, ovf8, s8}, e);
            end
         end
         check_eq($sformatf("sw1_latency_%0d", i), lat1, 1);
         check_eq($sformatf("sw8_latency_%0d", i), lat8, 8);
         @(posedge clock); #1;
      end

      check_eq("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
